// File: rtl/ctrl_decode_stage_if.sv
// Decode-stage bus: upstream instruction handshake, EX-stage load-use info,
// flush, downstream handshake, decoded control fields and perf counters.
// Modports:
//   master - the surrounding pipeline (drives instructions, consumes controls)
//   slave  - the decode stage itself
// ALUOP_W and CNT_W must match the parameters of the attached ctrl_decode_stage.
interface ctrl_decode_stage_if #(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CNT_W   = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        inst;
  logic               ex_valid;
  logic               ex_mem_read;
  logic [4:0]         ex_rd;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         br_type;
  logic               branch;
  logic               jal;
  logic               jalr;
  logic [1:0]         reg_src;
  logic [ALUOP_W-1:0] alu_op;
  logic               alu_src;
  logic               mem_read;
  logic               mem_write;
  logic               reg_write;
  logic               lui;
  logic               auipc;
  logic               illegal;
  logic [4:0]         rd;
  logic [4:0]         rs1;
  logic [4:0]         rs2;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   illegal_cnt;

  modport master (
    output in_valid, inst, ex_valid, ex_mem_read, ex_rd, flush, out_ready,
    input  in_ready, out_valid, br_type, branch, jal, jalr, reg_src, alu_op, alu_src,
           mem_read, mem_write, reg_write, lui, auipc, illegal, rd, rs1, rs2,
           stall_cnt, illegal_cnt
  );

  modport slave (
    input  in_valid, inst, ex_valid, ex_mem_read, ex_rd, flush, out_ready,
    output in_ready, out_valid, br_type, branch, jal, jalr, reg_src, alu_op, alu_src,
           mem_read, mem_write, reg_write, lui, auipc, illegal, rd, rs1, rs2,
           stall_cnt, illegal_cnt
  );
endinterface

// File: rtl/ctrl_decode_stage.sv
// RV32I subset decode stage with load-use stall, flush and a registered output.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - ctrl_decode_stage_if.slave (handshakes, EX info, flush, decoded outputs)
// Optional macro CTRL_DECODE_PERF_EN enables the saturating stall/illegal counters;
// without it the counter outputs are tied to zero.
module ctrl_decode_stage #(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CNT_W   = 16
) (
  input logic               clk,
  input logic               rst,
  ctrl_decode_stage_if.slave bus
);
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [ALUOP_W-1:0] AluAdd  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AluSub  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AluAnd  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AluOr   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] AluXor  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] AluSll  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] AluSrl  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] AluSra  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] AluSlt  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] AluSltu = ALUOP_W'(9);

  typedef struct packed {
    logic [2:0]         br_type;
    logic               branch;
    logic               jal;
    logic               jalr;
    logic [1:0]         reg_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               lui;
    logic               auipc;
    logic               illegal;
  } ctrl_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [4:0] rs1, rs2;
  assign opcode   = bus.inst[6:0];
  assign funct3   = bus.inst[14:12];
  assign funct7b5 = bus.inst[30];
  assign rs1      = bus.inst[19:15];
  assign rs2      = bus.inst[24:20];

  logic unused_inst;
  assign unused_inst = ^{bus.inst[31], bus.inst[29:25]};

  ctrl_t dec;
  always_comb begin
    dec = '0;
    unique case (opcode)
      OpR, OpI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = (opcode == OpI);
        case (funct3)
          3'b000: dec.alu_op = (opcode == OpR && funct7b5) ? AluSub : AluAdd;
          3'b001: begin dec.alu_op = AluSll;  dec.illegal = funct7b5; end
          3'b010: begin dec.alu_op = AluSlt;  dec.illegal = funct7b5 & (opcode == OpR); end
          3'b011: begin dec.alu_op = AluSltu; dec.illegal = funct7b5 & (opcode == OpR); end
          3'b100: begin dec.alu_op = AluXor;  dec.illegal = funct7b5 & (opcode == OpR); end
          3'b101: dec.alu_op = funct7b5 ? AluSra : AluSrl;
          3'b110: begin dec.alu_op = AluOr;   dec.illegal = funct7b5 & (opcode == OpR); end
          default: begin dec.alu_op = AluAnd; dec.illegal = funct7b5 & (opcode == OpR); end
        endcase
      end
      OpLoad: begin
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.reg_src   = 2'b01;
        dec.illegal   = (funct3 != 3'b010);
      end
      OpStore: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.illegal   = (funct3 != 3'b010);
      end
      OpBranch: begin
        dec.branch  = 1'b1;
        dec.br_type = funct3;
        dec.alu_op  = AluSub;
        dec.illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OpJal: begin
        dec.jal       = 1'b1;
        dec.reg_write = 1'b1;
        dec.reg_src   = 2'b10;
      end
      OpJalr: begin
        dec.jalr      = 1'b1;
        dec.reg_write = 1'b1;
        dec.reg_src   = 2'b10;
        dec.alu_src   = 1'b1;
        dec.illegal   = (funct3 != 3'b000);
      end
      OpLui: begin
        dec.lui       = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OpAuipc: begin
        dec.auipc     = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // A trap carries only the illegal flag so nothing downstream has side effects.
    if (dec.illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  logic rs1_used, rs2_used, hazard, out_free, accept;
  logic out_valid_q;
  ctrl_t ctrl_q;
  logic [4:0] rd_q, rs1_q, rs2_q;

  assign rs1_used = !(opcode inside {OpLui, OpAuipc, OpJal});
  assign rs2_used = opcode inside {OpR, OpStore, OpBranch};
  assign hazard   = bus.in_valid & bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                    ((rs1_used & (rs1 == bus.ex_rd)) | (rs2_used & (rs2 == bus.ex_rd)));
  assign out_free = bus.out_ready | !out_valid_q;
  // Flush always consumes (and drops) whatever is presented.
  assign bus.in_ready = !rst & (bus.flush | (!hazard & out_free));
  assign accept       = bus.in_valid & bus.in_ready & !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
    end else if (bus.flush || (out_free && !accept)) begin
      // Bubble: flushed, hazard-stalled, or nothing offered.
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      ctrl_q      <= dec;
      rd_q        <= bus.inst[11:7];
      rs1_q       <= rs1;
      rs2_q       <= rs2;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.br_type   = ctrl_q.br_type;
  assign bus.branch    = ctrl_q.branch;
  assign bus.jal       = ctrl_q.jal;
  assign bus.jalr      = ctrl_q.jalr;
  assign bus.reg_src   = ctrl_q.reg_src;
  assign bus.alu_op    = ctrl_q.alu_op;
  assign bus.alu_src   = ctrl_q.alu_src;
  assign bus.mem_read  = ctrl_q.mem_read;
  assign bus.mem_write = ctrl_q.mem_write;
  assign bus.reg_write = ctrl_q.reg_write;
  assign bus.lui       = ctrl_q.lui;
  assign bus.auipc     = ctrl_q.auipc;
  assign bus.illegal   = ctrl_q.illegal;
  assign bus.rd        = rd_q;
  assign bus.rs1       = rs1_q;
  assign bus.rs2       = rs2_q;

`ifdef CTRL_DECODE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, illegal_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q   <= '0;
      illegal_cnt_q <= '0;
    end else begin
      if (hazard && !bus.flush && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (accept && dec.illegal && illegal_cnt_q != '1) begin
        illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.illegal_cnt = illegal_cnt_q;
`else
  assign bus.stall_cnt   = '0;
  assign bus.illegal_cnt = '0;
`endif
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Self-checking bench for ctrl_decode_stage: directed scenarios plus a randomized run,
// all compared against a cycle-level reference model built from the instruction tables.
module tb_ctrl_decode_stage;
  localparam int unsigned CntMax = 65535;
  localparam int AluByF3 [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
  localparam logic [6:0] Ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67,
                                     7'h37, 7'h17};

  typedef struct packed {
    logic       out_valid;
    logic [2:0] br_type;
    logic       branch, jal, jalr;
    logic [1:0] reg_src;
    logic [3:0] alu_op;
    logic       alu_src, mem_read, mem_write, reg_write, lui, auipc, illegal;
    logic [4:0] rd, rs1, rs2;
  } outs_t;

  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned errors;

  outs_t       exp_q;
  int unsigned exp_stall;
  int unsigned exp_illegal;

  ctrl_decode_stage_if #(.ALUOP_W(4), .CNT_W(16)) bus ();

  ctrl_decode_stage #(.ALUOP_W(4), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode straight from the instruction tables.
  function automatic outs_t ref_decode(logic [31:0] i);
    outs_t o;
    logic [6:0] op;
    logic [2:0] f3;
    logic f7;
    bit ok;
    o = '0;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[30];
    ok = 1;
    o.out_valid = 1'b1;
    o.rd  = i[11:7];
    o.rs1 = i[19:15];
    o.rs2 = i[24:20];
    case (op)
      7'h33: begin
        o.reg_write = 1;
        o.alu_op = 4'(AluByF3[f3] + ((f7 && (f3 == 3'd0 || f3 == 3'd5)) ? 1 : 0));
        ok = !f7 || f3 == 3'd0 || f3 == 3'd5;
      end
      7'h13: begin
        o.reg_write = 1;
        o.alu_src = 1;
        o.alu_op = 4'(AluByF3[f3] + ((f7 && f3 == 3'd5) ? 1 : 0));
        ok = !(f3 == 3'd1 && f7);
      end
      7'h03: begin
        o.mem_read = 1; o.reg_write = 1; o.alu_src = 1; o.reg_src = 2'b01;
        ok = (f3 == 3'd2);
      end
      7'h23: begin
        o.mem_write = 1; o.alu_src = 1;
        ok = (f3 == 3'd2);
      end
      7'h63: begin
        o.branch = 1; o.br_type = f3; o.alu_op = 4'd1;
        ok = (f3 != 3'd2) && (f3 != 3'd3);
      end
      7'h6f: begin o.jal = 1; o.reg_write = 1; o.reg_src = 2'b10; end
      7'h67: begin
        o.jalr = 1; o.reg_write = 1; o.reg_src = 2'b10; o.alu_src = 1;
        ok = (f3 == 3'd0);
      end
      7'h37: begin o.lui = 1; o.reg_write = 1; o.alu_src = 1; end
      7'h17: begin o.auipc = 1; o.reg_write = 1; o.alu_src = 1; end
      default: ok = 0;
    endcase
    if (!ok) begin
      o = '0;
      o.out_valid = 1'b1;
      o.illegal = 1'b1;
      o.rd  = i[11:7];
      o.rs1 = i[19:15];
      o.rs2 = i[24:20];
    end
    return o;
  endfunction

  function automatic bit model_hazard();
    logic [6:0] op;
    bit u1, u2;
    op = bus.inst[6:0];
    u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6f);
    u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
    return bus.in_valid && bus.ex_valid && bus.ex_mem_read && bus.ex_rd != 5'd0 &&
           ((u1 && bus.inst[19:15] == bus.ex_rd) || (u2 && bus.inst[24:20] == bus.ex_rd));
  endfunction

  function automatic logic model_in_ready();
    if (rst) return 1'b0;
    if (bus.flush) return 1'b1;
    return !model_hazard() && (bus.out_ready || !exp_q.out_valid);
  endfunction

  function automatic outs_t dut_vec();
    outs_t o;
    o.out_valid = bus.out_valid; o.br_type = bus.br_type; o.branch = bus.branch;
    o.jal = bus.jal; o.jalr = bus.jalr; o.reg_src = bus.reg_src; o.alu_op = bus.alu_op;
    o.alu_src = bus.alu_src; o.mem_read = bus.mem_read; o.mem_write = bus.mem_write;
    o.reg_write = bus.reg_write; o.lui = bus.lui; o.auipc = bus.auipc;
    o.illegal = bus.illegal; o.rd = bus.rd; o.rs1 = bus.rs1; o.rs2 = bus.rs2;
    return o;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    outs_t d;
    bit hz, rdy;
    d = ref_decode(bus.inst);
    hz = model_hazard();
    rdy = model_in_ready();
    if (rst) begin
      exp_q = '0;
      exp_stall = 0;
      exp_illegal = 0;
    end else begin
`ifdef CTRL_DECODE_PERF_EN
      if (hz && !bus.flush && exp_stall < CntMax) exp_stall++;
      if (bus.in_valid && rdy && !bus.flush && d.illegal && exp_illegal < CntMax) exp_illegal++;
`endif
      if (bus.flush) exp_q = '0;
      else if (exp_q.out_valid && !bus.out_ready) exp_q = exp_q;
      else if (hz) exp_q = '0;
      else if (bus.in_valid) exp_q = d;
      else exp_q = '0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.inst = '0; bus.ex_valid = 0; bus.ex_mem_read = 0;
    bus.ex_rd = '0; bus.flush = 0; bus.out_ready = 1;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    bus.in_valid = 1;
    bus.inst = 32'h002081B3;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    end
    tick();
    tick();
    checks++;
    if (dut_vec() !== outs_t'(0)) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", dut_vec());
    end
    checks++;
    if (bus.stall_cnt !== 16'd0 || bus.illegal_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0",
                         bus.stall_cnt, bus.illegal_cnt);
    end
    rst = 0;
    bus.in_valid = 0;
  endtask

  task automatic test_add();
    do_reset();
    bus.in_valid = 1;
    bus.inst = 32'h002081B3;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL add_in_ready: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1 || bus.alu_op !== 4'd0 || bus.reg_write !== 1 ||
        bus.reg_src !== 2'b00 || bus.rd !== 5'd3 || bus.rs1 !== 5'd1 || bus.rs2 !== 5'd2) begin
      errors++; $display("FAIL add_decode: got v=%b op=%0d rw=%b src=%b rd=%0d rs1=%0d rs2=%0d want 1 0 1 00 3 1 2",
                         bus.out_valid, bus.alu_op, bus.reg_write, bus.reg_src, bus.rd, bus.rs1, bus.rs2);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_bubble: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.in_valid = 1;
    bus.inst = 32'h402081B3;
    tick();
    checks++;
    if (bus.out_valid !== 1 || bus.alu_op !== 4'd1) begin
      errors++; $display("FAIL sub_decode: got v=%b op=%0d want 1 1", bus.out_valid, bus.alu_op);
    end
    bus.inst = 32'h0000A283;
    tick();
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1 || bus.mem_read !== 1 || bus.alu_src !== 1 ||
        bus.reg_src !== 2'b01 || bus.rd !== 5'd5) begin
      errors++; $display("FAIL lw_decode: got v=%b mr=%b as=%b src=%b rd=%0d want 1 1 1 01 5",
                         bus.out_valid, bus.mem_read, bus.alu_src, bus.reg_src, bus.rd);
    end
    checks++;
    if (dut_vec() !== exp_q) begin
      errors++; $display("FAIL lw_model: got %h want %h", dut_vec(), exp_q);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    bus.in_valid = 1;
    bus.inst = 32'h00228333;
    bus.ex_valid = 1;
    bus.ex_mem_read = 1;
    bus.ex_rd = 5'd5;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL load_use_stall: got in_ready=%b want 0", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || dut_vec() !== outs_t'(0)) begin
      errors++; $display("FAIL load_use_bubble: got %h want 0", dut_vec());
    end
    bus.ex_mem_read = 0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL load_use_release: got in_ready=%b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 0;
    bus.ex_valid = 0;
    checks++;
    if (bus.out_valid !== 1 || bus.rd !== 5'd6 || bus.rs1 !== 5'd5 || bus.alu_op !== 4'd0) begin
      errors++; $display("FAIL load_use_accept: got v=%b rd=%0d rs1=%0d op=%0d want 1 6 5 0",
                         bus.out_valid, bus.rd, bus.rs1, bus.alu_op);
    end
    checks++;
`ifdef CTRL_DECODE_PERF_EN
    if (bus.stall_cnt !== 16'd1) begin
      errors++; $display("FAIL stall_cnt: got %0d want 1", bus.stall_cnt);
    end
`else
    if (bus.stall_cnt !== 16'd0) begin
      errors++; $display("FAIL stall_cnt: got %0d want 0", bus.stall_cnt);
    end
`endif
  endtask

  task automatic test_illegal();
    do_reset();
    bus.in_valid = 1;
    bus.inst = 32'hFFFFFFFF;
    tick();
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1 || bus.illegal !== 1 || bus.reg_write !== 0 || bus.mem_write !== 0) begin
      errors++; $display("FAIL illegal_decode: got v=%b il=%b rw=%b mw=%b want 1 1 0 0",
                         bus.out_valid, bus.illegal, bus.reg_write, bus.mem_write);
    end
    checks++;
`ifdef CTRL_DECODE_PERF_EN
    if (bus.illegal_cnt !== 16'd1) begin
      errors++; $display("FAIL illegal_cnt: got %0d want 1", bus.illegal_cnt);
    end
`else
    if (bus.illegal_cnt !== 16'd0) begin
      errors++; $display("FAIL illegal_cnt: got %0d want 0", bus.illegal_cnt);
    end
`endif
  endtask

  task automatic test_flush();
    do_reset();
    bus.in_valid = 1;
    bus.inst = 32'h002081B3;
    tick();
    // Output now occupied; stall downstream and present a hazard plus flush.
    bus.out_ready = 0;
    bus.inst = 32'h00228333;
    bus.ex_valid = 1;
    bus.ex_mem_read = 1;
    bus.ex_rd = 5'd5;
    bus.flush = 1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_bubble: got out_valid=%b want 0", bus.out_valid);
    end
    checks++;
    if (bus.stall_cnt !== 16'd0) begin
      errors++; $display("FAIL flush_stall_cnt: got %0d want 0", bus.stall_cnt);
    end
  endtask

  task automatic test_backpressure_reset();
    outs_t held;
    do_reset();
    bus.in_valid = 1;
    bus.inst = 32'h002081B3;
    tick();
    held = ref_decode(32'h002081B3);
    bus.out_ready = 0;
    bus.inst = 32'h402081B3;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_in_ready[%0d]: got %b want 0", k, bus.in_ready);
      end
      tick();
      checks++;
      if (dut_vec() !== held) begin
        errors++; $display("FAIL hold_outputs[%0d]: got %h want %h", k, dut_vec(), held);
      end
    end
    rst = 1;
    tick();
    rst = 0;
    idle_inputs();
    checks++;
    if (dut_vec() !== outs_t'(0) || bus.stall_cnt !== 16'd0 || bus.illegal_cnt !== 16'd0) begin
      errors++; $display("FAIL midstall_reset: got %h want 0", dut_vec());
    end
  endtask

  function automatic logic [31:0] rand_inst();
    if ($urandom_range(0, 3) == 0) return $urandom();
    return {1'b0, 1'($urandom_range(0, 1)), 5'($urandom()), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 3'($urandom()), 5'($urandom_range(0, 7)),
            Ops[$urandom_range(0, 8)]};
  endfunction

  task automatic test_random();
    logic want_rdy;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.inst = rand_inst();
      bus.ex_valid = ($urandom_range(0, 1) == 1);
      bus.ex_mem_read = ($urandom_range(0, 1) == 1);
      bus.ex_rd = 5'($urandom_range(0, 7));
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      #1;
      want_rdy = model_in_ready();
      checks++;
      if (bus.in_ready !== want_rdy) begin
        errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", n, bus.in_ready, want_rdy);
      end
      tick();
      checks++;
      if (dut_vec() !== exp_q) begin
        errors++; $display("FAIL rand_outputs[%0d]: got %h want %h", n, dut_vec(), exp_q);
      end
      checks++;
      if (bus.stall_cnt !== 16'(exp_stall) || bus.illegal_cnt !== 16'(exp_illegal)) begin
        errors++; $display("FAIL rand_counters[%0d]: got %0d/%0d want %0d/%0d", n,
                           bus.stall_cnt, bus.illegal_cnt, exp_stall, exp_illegal);
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_q = '0;
    exp_stall = 0;
    exp_illegal = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_add();
    test_back_to_back();
    test_load_use();
    test_illegal();
    test_flush();
    test_backpressure_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
